// File: rtl/keyboard_interface_if.sv
`default_nettype none
// ============================================================================
// Module  : keyboard_interface_if
// Brief   : Scan-code request and PS/2 line bundle for keyboard_interface.
// Rev     : 1.0
// ============================================================================
interface keyboard_interface_if;
  logic       key_action;
  logic [7:0] scan_code;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [2:0] ps2_lock_control;

  modport master (
    output key_action,
    output scan_code,
    input  ps2_clk,
    input  ps2_dat,
    input  ps2_lock_control
  );

  modport slave (
    input  key_action,
    input  scan_code,
    output ps2_clk,
    output ps2_dat,
    output ps2_lock_control
  );
endinterface
`default_nettype wire

// File: rtl/keyboard_interface.sv
`default_nettype none
// ============================================================================
// Module  : keyboard_interface
// Brief   : PS/2 keyboard device model: FIFO-buffered scan codes serialised as
//           11-bit device-to-host frames; lock tracking under KEYBOARD_LOCK_TRACK_EN.
// Rev     : 1.0
// ============================================================================
module keyboard_interface #(
  parameter int HALF_PERIOD = 2500,
  parameter int FIFO_DEPTH  = 16,
  parameter int IDLE_GAP    = 2
) (
  input  wire logic           CLOCK_50,
  input  wire logic           reset,
  keyboard_interface_if.slave bus
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int BIT_CYC = 2 * HALF_PERIOD;
  localparam int GAP_CYC = IDLE_GAP * BIT_CYC;
  localparam int CNT_MAX = (BIT_CYC > GAP_CYC) ? BIT_CYC : GAP_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] c_half_last = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] c_bit_last  = CW'(BIT_CYC - 1);
  // The idle state adds one more high cycle before the next start bit.
  localparam logic [CW-1:0] c_gap_last  = CW'(GAP_CYC - 2);
  localparam logic [3:0]    c_stop_idx  = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_BIT  = 2'd2
  } state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_head;

  state_t        r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [3:0]    r_bit, w_bit_n;
  logic [9:0]    r_frame, w_frame_n;
  logic          r_clk, w_clk_n;
  logic          r_dat, w_dat_n;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_head  = r_mem[r_rptr[AW-1:0]];
  assign w_push  = bus.key_action && (!w_full || w_pop);

  always_ff @(posedge CLOCK_50) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= bus.scan_code;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_frame <= '1;
      r_clk   <= 1'b1;
      r_dat   <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_frame <= w_frame_n;
      r_clk   <= w_clk_n;
      r_dat   <= w_dat_n;
    end
  end

  // r_frame holds the bits still to be sent after the one on the line, LSB next.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_bit_n   = r_bit;
    w_frame_n = r_frame;
    w_clk_n   = r_clk;
    w_dat_n   = r_dat;
    w_pop     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_clk_n = 1'b1;
        w_dat_n = 1'b1;
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_frame_n = {1'b1, ~^w_head, w_head};
          w_dat_n   = 1'b0;
          w_cnt_n   = '0;
          w_bit_n   = '0;
          w_state_n = S_BIT;
        end
      end
      S_BIT: begin
        if (r_cnt == c_bit_last) begin
          w_cnt_n = '0;
          w_clk_n = 1'b1;
          if (r_bit == c_stop_idx) begin
            w_dat_n   = 1'b1;
            w_state_n = S_GAP;
          end else begin
            w_dat_n   = r_frame[0];
            w_frame_n = {1'b1, r_frame[9:1]};
            w_bit_n   = r_bit + 1'b1;
          end
        end else begin
          w_cnt_n = r_cnt + 1'b1;
          w_clk_n = (r_cnt >= c_half_last) ? 1'b0 : 1'b1;
        end
      end
      S_GAP: begin
        w_clk_n = 1'b1;
        w_dat_n = 1'b1;
        if (r_cnt >= c_gap_last) begin
          w_cnt_n   = '0;
          w_state_n = S_IDLE;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_clk_n   = 1'b1;
        w_dat_n   = 1'b1;
      end
    endcase
  end

  assign bus.ps2_clk = r_clk;
  assign bus.ps2_dat = r_dat;

`ifdef KEYBOARD_LOCK_TRACK_EN
  logic       r_brk;
  logic [2:0] r_lock;

  // A break prefix suppresses the toggle of the following make code.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_brk  <= 1'b0;
      r_lock <= 3'b000;
    end else if (w_pop) begin
      case (w_head)
        8'hF0: r_brk <= 1'b1;
        8'hE0: r_brk <= r_brk;
        default: begin
          if (!r_brk) begin
            case (w_head)
              8'h58:   r_lock[0] <= ~r_lock[0];
              8'h77:   r_lock[1] <= ~r_lock[1];
              8'h7E:   r_lock[2] <= ~r_lock[2];
              default: r_lock    <= r_lock;
            endcase
          end
          r_brk <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ps2_lock_control = r_lock;
`else
  assign bus.ps2_lock_control = 3'b000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_keyboard_interface.sv
`default_nettype none
// ============================================================================
// Module  : tb_keyboard_interface
// Brief   : Scoreboard bench: pushes scan codes, decodes PS/2 frames on the lines.
// Rev     : 1.0
// ============================================================================
module tb_keyboard_interface;
  localparam int HP    = 4;
  localparam int DEPTH = 16;
  localparam int GAPP  = 2;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;

  keyboard_interface_if bus();

  keyboard_interface #(
    .HALF_PERIOD (HP),
    .FIFO_DEPTH  (DEPTH),
    .IDLE_GAP    (GAPP)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] stim_q[$];
  logic [2:0] exp_lock = 3'b000;
  logic       exp_brk  = 1'b0;

  int         cyc = 0, t0 = 0, last_fall = 0, nbits = 0, hi_run = 0;
  int         frames = 0, total_falls = 0;
  bit         in_frame = 0, end_wait = 0, prev_clk = 1, chk_gap = 0, gap_skip = 0;
  logic [10:0] shreg;
  logic [7:0]  m_exp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_lock(input logic [7:0] b);
    if (b == 8'hF0) exp_brk = 1'b1;
    else if (b != 8'hE0) begin
      if (!exp_brk) begin
`ifdef KEYBOARD_LOCK_TRACK_EN
        if (b == 8'h58) exp_lock[0] = ~exp_lock[0];
        if (b == 8'h77) exp_lock[1] = ~exp_lock[1];
        if (b == 8'h7E) exp_lock[2] = ~exp_lock[2];
`endif
      end
      exp_brk = 1'b0;
    end
  endtask

  // Frame decoder and scoreboard, sampling on the falling system-clock edge.
  always @(negedge CLOCK_50) begin
    cyc++;
    if (reset) begin
      in_frame = 0;
      end_wait = 0;
      nbits    = 0;
      hi_run   = 0;
      prev_clk = 1;
      exp_q.delete();
    end else begin
      if (prev_clk && !bus.ps2_clk) total_falls++;
      if (!in_frame && !end_wait && bus.ps2_clk && !bus.ps2_dat) begin
        in_frame = 1;
        t0       = cyc;
        nbits    = 0;
        if (chk_gap) begin
          if (gap_skip) gap_skip = 0;
          else check_eq("gap_high_cycles", hi_run, 2 * HP * GAPP);
        end
      end
      if (in_frame && prev_clk && !bus.ps2_clk) begin
        if (nbits == 0) check_eq("first_fall_delay", cyc - t0, HP);
        else            check_eq("fall_spacing", cyc - last_fall, 2 * HP);
        last_fall     = cyc;
        shreg[nbits]  = bus.ps2_dat;
        nbits++;
        if (nbits == 11) begin
          in_frame = 0;
          end_wait = 1;
          check_eq("frame_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            m_exp = exp_q.pop_front();
            check_eq("start_bit", shreg[0], 0);
            check_eq("data_byte", shreg[8:1], m_exp);
            check_eq("parity_bit", shreg[9], ~^m_exp);
            check_eq("stop_bit", shreg[10], 1);
          end
        end
      end
      if (end_wait && bus.ps2_clk) begin
        check_eq("frame_length", cyc - t0, 22 * HP);
        check_eq("post_frame_dat", bus.ps2_dat, 1);
        end_wait = 0;
        frames++;
      end
      hi_run   = (bus.ps2_clk && bus.ps2_dat) ? hi_run + 1 : 0;
      prev_clk = bus.ps2_clk;
    end
  end

  task automatic send(input int n_accept);
    int         k;
    logic [7:0] b;
    k = 0;
    while (stim_q.size() > 0) begin
      b = stim_q.pop_front();
      @(negedge CLOCK_50);
      bus.key_action = 1'b1;
      bus.scan_code  = b;
      if (k < n_accept) begin
        exp_q.push_back(b);
        model_lock(b);
      end
      k++;
    end
    @(negedge CLOCK_50);
    bus.key_action = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int i;
    for (i = 0; i < 6000; i++) begin
      @(negedge CLOCK_50);
      if (exp_q.size() == 0 && !in_frame && !end_wait) break;
    end
    check_eq({tag, "_idle_reached"}, i < 6000, 1);
    repeat (24) @(negedge CLOCK_50);
    check_eq({tag, "_idle_clk"}, bus.ps2_clk, 1);
    check_eq({tag, "_idle_dat"}, bus.ps2_dat, 1);
    check_eq({tag, "_lock"}, bus.ps2_lock_control, exp_lock);
  endtask

  initial begin
    int f0, falls0, i;
    bus.key_action = 1'b0;
    bus.scan_code  = 8'h00;
    repeat (3) @(negedge CLOCK_50);
    check_eq("reset_clk", bus.ps2_clk, 1);
    check_eq("reset_dat", bus.ps2_dat, 1);
    check_eq("reset_lock", bus.ps2_lock_control, 3'b000);
    reset = 1'b0;
    repeat (2) @(negedge CLOCK_50);

    stim_q.push_back(8'h1C);
    send(1);
    @(negedge CLOCK_50);
    check_eq("latency_dat_low", bus.ps2_dat, 0);
    check_eq("latency_clk_high", bus.ps2_clk, 1);
    wait_idle("b1C");

    stim_q.push_back(8'h00);
    send(1);
    wait_idle("b00");

    chk_gap  = 1;
    gap_skip = 1;
    stim_q.push_back(8'hE0);
    stim_q.push_back(8'hF0);
    stim_q.push_back(8'h1C);
    send(3);
    wait_idle("b2b");
    chk_gap = 0;

    stim_q.push_back(8'h58);
    send(1);
    wait_idle("caps_on");
    stim_q.push_back(8'hF0);
    stim_q.push_back(8'h58);
    send(2);
    wait_idle("caps_break");
    stim_q.push_back(8'h58);
    send(1);
    wait_idle("caps_off");
    stim_q.push_back(8'h77);
    stim_q.push_back(8'h7E);
    send(2);
    wait_idle("num_scroll");

    f0       = frames;
    chk_gap  = 1;
    gap_skip = 1;
    for (int j = 0; j < 18; j++) stim_q.push_back(8'h20 + 8'(j));
    send(17);
    wait_idle("fifo_full");
    chk_gap = 0;
    check_eq("fifo_full_frames", frames - f0, 17);

    stim_q.push_back(8'h3A);
    send(1);
    for (i = 0; i < 500 && nbits < 5; i++) @(negedge CLOCK_50);
    check_eq("reach_bit5", nbits >= 5, 1);
    repeat (6) @(negedge CLOCK_50);
    reset    = 1'b1;
    exp_lock = 3'b000;
    exp_brk  = 1'b0;
    @(negedge CLOCK_50);
    check_eq("midreset_clk", bus.ps2_clk, 1);
    check_eq("midreset_dat", bus.ps2_dat, 1);
    check_eq("midreset_lock", bus.ps2_lock_control, 3'b000);
    @(negedge CLOCK_50);
    reset  = 1'b0;
    falls0 = total_falls;
    repeat (200) @(negedge CLOCK_50);
    check_eq("no_falls_after_reset", total_falls - falls0, 0);
    check_eq("post_reset_dat", bus.ps2_dat, 1);

    stim_q.push_back(8'h5A);
    send(1);
    wait_idle("recover");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/keyboard_interface.md
Name: keyboard_interface

Overview:
- Behavioural PS/2 keyboard device model used in the simulation harness.
- Accepts one-cycle scan-code requests from the host-side environment and buffers them in a FIFO.
- Serialises each byte as a standard 11-bit PS/2 device-to-host frame on ps2_clk/ps2_dat toward the design's PS/2 receiver.
- Tracks Caps/Num/Scroll lock state from the transmitted code stream.

Parameters:
- HALF_PERIOD, 2500: CLOCK_50 cycles per ps2_clk phase (high or low); default gives 10 kHz; must be >= 2.
- FIFO_DEPTH, 16: scan-code buffer entries; power of two.
- IDLE_GAP, 2: idle ps2_clk periods (2*HALF_PERIOD cycles each) held high between frames.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- key_action  input  1  one-cycle strobe: enqueue scan_code.
- scan_code  input  8  byte to send, valid when key_action=1.
- ps2_clk  output  1  PS/2 clock, idle high.
- ps2_dat  output  1  PS/2 data, idle high.
- ps2_lock_control  output  3  {scroll, num, caps} lock state; bit0=caps, bit1=num, bit2=scroll.

Behaviour:
- Reset (synchronous, active-high):
  - ps2_clk=1, ps2_dat=1, ps2_lock_control=3'b000.
  - FIFO emptied; FSM to IDLE; break-prefix flag cleared.
  - Reset mid-frame aborts the frame immediately; lines go high on the next edge.
- Enqueue:
  - On any edge with key_action=1 and FIFO not full, scan_code is pushed.
  - When the FIFO is full, the byte is dropped silently and state is unchanged.
  - Simultaneous push and pop on a full FIFO is allowed.
- FSM states: IDLE, GAP, BIT.
  - IDLE -> BIT when the FIFO is non-empty: pop the byte, build frame {stop=1, odd parity, d7..d0, start=0}, bit index k=0.
  - BIT: bit k occupies 2*HALF_PERIOD cycles.
    - ps2_dat is driven to bit k at the start of the bit (ps2_clk high).
    - ps2_clk low for cycles HALF_PERIOD..2*HALF_PERIOD-1 of the bit; the host samples on the falling edge.
    - Bits go out LSB first after the start bit. Parity = ~^byte, so the count of ones in data+parity is odd.
    - After k=10 (stop bit) completes, ps2_clk=1, ps2_dat=1 -> GAP.
  - GAP: hold both lines high for IDLE_GAP*2*HALF_PERIOD cycles -> IDLE.
- Latency:
  - A byte written at edge N into an empty FIFO with the FSM idle drives ps2_dat low at edge N+1 (ps2_clk still high).
  - First ps2_clk falling edge occurs HALF_PERIOD cycles later.
  - Frame length is 22*HALF_PERIOD cycles.
- Back-to-back: queued bytes go out in FIFO order, separated only by the GAP interval.
- Lock tracking, updated when a byte is popped:
  - 0xF0 sets the break flag.
  - 0xE0 leaves the break flag unchanged.
  - Make codes 0x58 / 0x77 / 0x7E toggle caps / num / scroll respectively, only when the break flag is clear.
  - Any byte other than 0xF0 and 0xE0 clears the break flag after evaluation.
  - Other codes do not affect the lock bits.

Optional Feature:
- KEYBOARD_LOCK_TRACK_EN.
  - Defined: lock tracking as above.
  - Undefined: ps2_lock_control is tied to 3'b000, the break-flag logic is removed, and frame serialisation is identical.

Test Plan:
- HALF_PERIOD=4. Reset, push 0x1C. Required:
  - ps2_dat low the next cycle.
  - 11 falling edges of ps2_clk, 8 cycles apart.
  - Sampled bits 0,0,0,1,1,1,0,0,0,0,1 (parity 0).
  - Lines high afterwards.
- Push 0x00. Required: parity bit 1, stop 1; total frame 88 cycles.
- Push 0xE0, 0xF0, 0x1C on consecutive cycles. Required: three frames in that order; each stop bit followed by exactly 16 idle-high cycles.
- Push 0x58 -> ps2_lock_control=001. Push F0,58 -> stays 001. Push 58 -> 000. Push 77 then 7E -> 110.
- Push 17 bytes with FIFO_DEPTH=16 in consecutive cycles while the first frame is active. Required: exactly 16 or 17 frames per pop timing (first popped immediately, so 17 fit); an 18th push is dropped.
- Assert reset at mid-frame bit 5. Required: the next cycle has ps2_clk=1, ps2_dat=1 and lock=000; no further falling edges until a new push.
